// File: rtl/dly_stretch_gen.sv
// Per-channel programmable delay line followed by a retriggerable pulse stretcher.
// A configuration load clears the datapath and holds the outputs off while the delay lines refill.
module dly_stretch_gen #(
  parameter int NCHAN = 4,
  parameter int DEPTH = 16,
  parameter int DBITS = $clog2(DEPTH),
  parameter int WBITS = 4
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [NCHAN-1:0]       Channels,
  input  logic [NCHAN*DBITS-1:0] Delays,
  input  logic [NCHAN*WBITS-1:0] Widths,
  input  logic [NCHAN-1:0]       ChanEn,
  input  logic                   CfgLoad,
  output logic                   CfgBusy,
  output logic                   CfgDrop,
  output logic [NCHAN-1:0]       DlayChann,
  output logic [NCHAN-1:0]       PileUp
);

  localparam int FCW = $clog2(DEPTH + 2);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [FCW-1:0]         r_flush_cnt;
  logic                   w_load;
  logic                   w_drop;
  logic                   w_flush_last;
  logic                   w_run;
  logic [NCHAN*DBITS-1:0] r_dact;
  logic [NCHAN*WBITS-1:0] r_wact;
  logic [NCHAN-1:0]       r_en;
  logic [DEPTH-1:0]       r_sr_p0 [NCHAN];
  logic [NCHAN-1:0]       w_tap;
  logic [NCHAN-1:0]       w_rise;
  logic [NCHAN-1:0]       r_tap_p1;
  logic [NCHAN-1:0]       r_tap_q_p2;
  logic [WBITS-1:0]       r_cnt_p2 [NCHAN];

  function automatic logic [DBITS-1:0] clamp_dly(input logic [DBITS-1:0] d);
    if (int'(d) > DEPTH - 1) return DBITS'(DEPTH - 1);
    return d;
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_flush_last = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (CfgLoad) begin
          w_load      = 1'b1;
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        w_drop = CfgLoad;
        if (r_flush_cnt == FCW'(DEPTH)) begin
          w_flush_last = 1'b1;
          w_state_nxt  = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // A load edge clears the stretchers just like a flush cycle does.
  assign w_run = (r_state == ST_RUN) && !CfgLoad;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      CfgBusy     <= 1'b0;
      CfgDrop     <= 1'b0;
      r_dact      <= '0;
      r_wact      <= '0;
      r_en        <= '0;
    end else begin
      r_state <= w_state_nxt;
      CfgDrop <= w_drop;
      if (w_load) begin
        r_dact      <= Delays;
        r_wact      <= Widths;
        r_en        <= ChanEn;
        r_flush_cnt <= '0;
        CfgBusy     <= 1'b1;
      end else if (r_state == ST_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
        if (w_flush_last) CfgBusy <= 1'b0;
      end
    end
  end

  // Stage p0: delay lines
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (Rst || w_load) r_sr_p0[i] <= '0;
      else               r_sr_p0[i] <= {r_sr_p0[i][DEPTH-2:0], Channels[i]};
    end
  end

  always_comb begin
    w_tap  = '0;
    w_rise = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_tap[i]  = r_sr_p0[i][clamp_dly(r_dact[i*DBITS +: DBITS])];
      w_rise[i] = r_tap_p1[i] & ~r_tap_q_p2[i];
    end
  end

  // Stage p1/p2: registered tap, edge detect and stretch counter
  always_ff @(posedge Clk) begin
    for (int i = 0; i < NCHAN; i++) begin
      if (Rst || !w_run || !r_en[i]) begin
        r_tap_p1[i]   <= 1'b0;
        r_tap_q_p2[i] <= 1'b0;
        r_cnt_p2[i]   <= '0;
        DlayChann[i]  <= 1'b0;
        PileUp[i]     <= 1'b0;
      end else begin
        r_tap_p1[i]   <= w_tap[i];
        r_tap_q_p2[i] <= r_tap_p1[i];
        PileUp[i]     <= w_rise[i] & DlayChann[i];
        if (w_rise[i]) begin
          r_cnt_p2[i]  <= r_wact[i*WBITS +: WBITS];
          DlayChann[i] <= 1'b1;
        end else if (r_cnt_p2[i] != '0) begin
          r_cnt_p2[i]  <= r_cnt_p2[i] - 1'b1;
          DlayChann[i] <= 1'b1;
        end else begin
          DlayChann[i] <= 1'b0;
        end
      end
    end
  end

endmodule
